// File: rtl/cpu_seq_pkg.sv
// Shared types and defaults for the CPU fetch/execute sequencer.
package cpu_seq_pkg;

   localparam logic [2:0] ENC_IDLE    = 3'd0;
   localparam logic [2:0] ENC_FETCH   = 3'd1;
   localparam logic [2:0] ENC_EXEC    = 3'd2;
   localparam logic [2:0] ENC_WAIT_IN = 3'd3;
   localparam logic [2:0] ENC_HALTED  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = ENC_IDLE,
      ST_FETCH   = ENC_FETCH,
      ST_EXEC    = ENC_EXEC,
      ST_WAIT_IN = ENC_WAIT_IN,
      ST_HALTED  = ENC_HALTED
   } seq_state_t;

   localparam logic [7:0] HALT_OPC_DEF = 8'hFF;
   localparam logic [1:0] SW_SEL_DEF   = 2'd2;
   localparam int         CNT_W_DEF    = 16;

endpackage

// File: rtl/sat_counter.sv
// Increment-enable counter that holds at all-ones instead of wrapping.
module sat_counter
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: gates ControlUnit strobes so each instruction commits
// in a single EXEC cycle, with run/step/halt, PC breakpoint and switch handshake.
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter logic [7:0] HALT_OPC = HALT_OPC_DEF,
   parameter logic [1:0] SW_SEL   = SW_SEL_DEF,
   parameter int         CNT_W    = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             run_i,
   input  logic             step_i,
   input  logic             halt_i,
   input  logic             bp_en_i,
   input  logic [7:0]       bp_addr_i,
   input  logic [7:0]       pc_i,
   input  logic [7:0]       opcode_i,
   input  logic [1:0]       cu_b_sel_i,
   input  logic [2:0]       cu_f_i,
   input  logic             cu_write_a_i,
   input  logic             cu_write_b_i,
   input  logic             cu_write_o_i,
   input  logic             cu_write_cz_i,
   input  logic             cu_write_pc_i,
   input  logic             cu_pc_sel_i,
   input  logic             in_valid_i,
   output logic             in_ack_o,
   output logic             write_a_o,
   output logic             write_b_o,
   output logic             write_o_o,
   output logic             write_cz_o,
   output logic             write_pc_o,
   output logic             pc_sel_o,
   output logic             pc_inc_o,
   output logic [2:0]       f_o,
   output logic [1:0]       b_sel_o,
   output logic [2:0]       state_o,
   output logic             bp_hit_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] instr_cnt_o
);

   seq_state_t r_state;
   seq_state_t w_state_nxt;
   logic       r_bp_hit;
   logic       r_bp_skip;
   logic       r_step_mode;
   logic       r_halted;
   logic       w_commit;
   logic       w_start;
   logic       w_step_start;
   logic       w_bp_trap;
   logic       w_sw_sel;

   assign w_sw_sel = (cu_b_sel_i == SW_SEL);

   always_comb begin
      w_state_nxt  = r_state;
      w_commit     = 1'b0;
      w_start      = 1'b0;
      w_step_start = 1'b0;
      w_bp_trap    = 1'b0;
      write_a_o    = 1'b0;
      write_b_o    = 1'b0;
      write_o_o    = 1'b0;
      write_cz_o   = 1'b0;
      write_pc_o   = 1'b0;
      pc_sel_o     = 1'b0;
      pc_inc_o     = 1'b0;
      in_ack_o     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (step_i) begin
               w_state_nxt  = ST_FETCH;
               w_start      = 1'b1;
               w_step_start = 1'b1;
            end else if (run_i && !halt_i) begin
               w_state_nxt = ST_FETCH;
               w_start     = 1'b1;
            end
         end
         ST_FETCH: begin
            // bp_skip lets the trapped instruction run once when execution resumes
            if (bp_en_i && (pc_i == bp_addr_i) && !r_bp_skip) begin
               w_state_nxt = ST_IDLE;
               w_bp_trap   = 1'b1;
            end else begin
               w_state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (opcode_i == HALT_OPC) begin
               w_state_nxt = ST_HALTED;
            end else if (w_sw_sel && !in_valid_i) begin
               w_state_nxt = ST_WAIT_IN;
            end else begin
               w_commit    = 1'b1;
               write_a_o   = cu_write_a_i;
               write_b_o   = cu_write_b_i;
               write_o_o   = cu_write_o_i;
               write_cz_o  = cu_write_cz_i;
               write_pc_o  = cu_write_pc_i;
               pc_sel_o    = cu_pc_sel_i;
               pc_inc_o    = !cu_write_pc_i;
               in_ack_o    = w_sw_sel;
               w_state_nxt = (r_step_mode || halt_i || !run_i) ? ST_IDLE : ST_FETCH;
            end
         end
         ST_WAIT_IN: begin
            // abandoning here leaves PC untouched, so the instruction re-fetches later
            if (halt_i) begin
               w_state_nxt = ST_IDLE;
            end else if (in_valid_i) begin
               w_state_nxt = ST_EXEC;
            end
         end
         ST_HALTED: begin
            w_state_nxt = ST_HALTED;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_bp_hit    <= 1'b0;
         r_bp_skip   <= 1'b0;
         r_step_mode <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_halted <= (w_state_nxt == ST_HALTED);
         if (w_start) begin
            r_step_mode <= w_step_start;
            r_bp_hit    <= 1'b0;
         end
         if (w_bp_trap) begin
            r_bp_hit  <= 1'b1;
            r_bp_skip <= 1'b1;
         end else if (w_commit) begin
            r_bp_skip <= 1'b0;
         end
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_instr_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .i_en  (w_commit),
      .o_cnt (instr_cnt_o)
   );

   assign f_o      = cu_f_i;
   assign b_sel_o  = cu_b_sel_i;
   assign state_o  = r_state;
   assign bp_hit_o = r_bp_hit;
   assign halted_o = r_halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus randomized run against an
// instruction-level reference model; a 4-bit-counter twin exercises saturation.
module tb_cpu_sequencer;
   import cpu_seq_pkg::*;

   localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_WAIT = 3, P_HALT = 4;

   logic clk = 1'b0;
   logic rstn;
   logic run_i, step_i, halt_i, bp_en_i;
   logic [7:0] bp_addr_i, pc_i, opcode_i;
   logic [1:0] cu_b_sel_i;
   logic [2:0] cu_f_i;
   logic cu_write_a_i, cu_write_b_i, cu_write_o_i, cu_write_cz_i, cu_write_pc_i, cu_pc_sel_i;
   logic in_valid_i;
   logic in_ack_o, write_a_o, write_b_o, write_o_o, write_cz_o, write_pc_o, pc_sel_o, pc_inc_o;
   logic [2:0] f_o, state_o;
   logic [1:0] b_sel_o;
   logic bp_hit_o, halted_o;
   logic [15:0] instr_cnt_o;
   logic s_in_ack, s_wa, s_wb, s_wo, s_wcz, s_wpc, s_pcsel, s_pcinc, s_bp, s_halted;
   logic [2:0] s_f, s_state;
   logic [1:0] s_bsel;
   logic [3:0] s_cnt;

   logic [7:0] rom [8];
   logic [7:0] jmp_tgt;
   int n_checks = 0;
   int n_err = 0;
   int n_wa_tot = 0;

   int m_ph, m_cnt;
   bit m_stepm, m_skip, m_bp;
   logic [7:0] m_pc;

   assign opcode_i = rom[pc_i[2:0]];

   always #5 clk = ~clk;

   cpu_sequencer dut (
      .clk(clk), .rstn(rstn), .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
      .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .pc_i(pc_i), .opcode_i(opcode_i),
      .cu_b_sel_i(cu_b_sel_i), .cu_f_i(cu_f_i), .cu_write_a_i(cu_write_a_i),
      .cu_write_b_i(cu_write_b_i), .cu_write_o_i(cu_write_o_i), .cu_write_cz_i(cu_write_cz_i),
      .cu_write_pc_i(cu_write_pc_i), .cu_pc_sel_i(cu_pc_sel_i), .in_valid_i(in_valid_i),
      .in_ack_o(in_ack_o), .write_a_o(write_a_o), .write_b_o(write_b_o), .write_o_o(write_o_o),
      .write_cz_o(write_cz_o), .write_pc_o(write_pc_o), .pc_sel_o(pc_sel_o), .pc_inc_o(pc_inc_o),
      .f_o(f_o), .b_sel_o(b_sel_o), .state_o(state_o), .bp_hit_o(bp_hit_o),
      .halted_o(halted_o), .instr_cnt_o(instr_cnt_o)
   );

   cpu_sequencer #(.CNT_W(4)) dut_s (
      .clk(clk), .rstn(rstn), .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
      .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .pc_i(pc_i), .opcode_i(opcode_i),
      .cu_b_sel_i(cu_b_sel_i), .cu_f_i(cu_f_i), .cu_write_a_i(cu_write_a_i),
      .cu_write_b_i(cu_write_b_i), .cu_write_o_i(cu_write_o_i), .cu_write_cz_i(cu_write_cz_i),
      .cu_write_pc_i(cu_write_pc_i), .cu_pc_sel_i(cu_pc_sel_i), .in_valid_i(in_valid_i),
      .in_ack_o(s_in_ack), .write_a_o(s_wa), .write_b_o(s_wb), .write_o_o(s_wo),
      .write_cz_o(s_wcz), .write_pc_o(s_wpc), .pc_sel_o(s_pcsel), .pc_inc_o(s_pcinc),
      .f_o(s_f), .b_sel_o(s_bsel), .state_o(s_state), .bp_hit_o(s_bp),
      .halted_o(s_halted), .instr_cnt_o(s_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic m_reset();
      m_ph = P_IDLE; m_cnt = 0; m_stepm = 0; m_skip = 0; m_bp = 0; m_pc = 8'd0;
   endtask

   // Instruction-level view: an instruction retires when its execute phase
   // is neither a halt opcode nor blocked on the switch input.
   function automatic bit m_retires();
      return (m_ph == P_EXEC) && (opcode_i != 8'hFF) && !(cu_b_sel_i == 2'd2 && !in_valid_i);
   endfunction

   task automatic m_check();
      logic [7:0] exp_str;
      exp_str = 8'h00;
      if (m_retires())
         exp_str = {cu_write_a_i, cu_write_b_i, cu_write_o_i, cu_write_cz_i, cu_write_pc_i,
                    cu_pc_sel_i, !cu_write_pc_i, (cu_b_sel_i == 2'd2)};
      chk("strobes", {write_a_o, write_b_o, write_o_o, write_cz_o, write_pc_o, pc_sel_o,
                      pc_inc_o, in_ack_o}, exp_str);
      chk("state", state_o, m_ph);
      chk("bp_hit", bp_hit_o, m_bp);
      chk("halted", halted_o, (m_ph == P_HALT));
      chk("instr_cnt", instr_cnt_o, sat(m_cnt, 65535));
      chk("instr_cnt_w4", s_cnt, sat(m_cnt, 15));
      chk("passthru", {f_o, b_sel_o}, {cu_f_i, cu_b_sel_i});
      chk("state_w4", s_state, m_ph);
   endtask

   task automatic m_advance();
      case (m_ph)
         P_IDLE: begin
            if (step_i) begin
               m_ph = P_FETCH; m_stepm = 1; m_bp = 0;
            end else if (run_i && !halt_i) begin
               m_ph = P_FETCH; m_stepm = 0; m_bp = 0;
            end
         end
         P_FETCH: begin
            if (bp_en_i && pc_i == bp_addr_i && !m_skip) begin
               m_ph = P_IDLE; m_bp = 1; m_skip = 1;
            end else begin
               m_ph = P_EXEC;
            end
         end
         P_EXEC: begin
            if (opcode_i == 8'hFF) m_ph = P_HALT;
            else if (cu_b_sel_i == 2'd2 && !in_valid_i) m_ph = P_WAIT;
            else begin
               m_cnt++;
               m_skip = 0;
               m_pc = cu_write_pc_i ? jmp_tgt : ((m_pc + 8'd1) & 8'h07);
               m_ph = (m_stepm || halt_i || !run_i) ? P_IDLE : P_FETCH;
            end
         end
         P_WAIT: begin
            if (halt_i) m_ph = P_IDLE;
            else if (in_valid_i) m_ph = P_EXEC;
         end
         default: ;
      endcase
   endtask

   task automatic run_model();
      forever begin
         @(negedge clk);
         if (!rstn) m_reset();
         m_check();
         if (write_a_o === 1'b1) n_wa_tot++;
         @(posedge clk);
         if (!rstn) m_reset();
         else m_advance();
         #1 pc_i = m_pc;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      sample();
      chk("rst_strobes", {write_a_o, write_b_o, write_o_o, write_cz_o, write_pc_o, pc_sel_o,
                          pc_inc_o, in_ack_o}, 8'h00);
      chk("rst_state", {state_o, bp_hit_o, halted_o}, 5'd0);
      chk("rst_cnt", instr_cnt_o, 16'd0);
      tick(2);
      rstn = 1'b1;
   endtask

   task automatic wait_state(input logic [2:0] st, input bit use_pc, input logic [7:0] pc,
                             input int maxc, input string nm);
      int k;
      k = 0;
      forever begin
         @(negedge clk);
         if (state_o == st && (!use_pc || pc_i == pc)) break;
         k++;
         if (k >= maxc) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: timeout, state=%0d pc=%0h wanted state=%0d", nm, state_o, pc_i, st);
            break;
         end
      end
   endtask

   task automatic rand_inputs();
      run_i      = ($urandom_range(0, 7) != 0);
      step_i     = ($urandom_range(0, 9) == 0);
      halt_i     = ($urandom_range(0, 11) == 0);
      cu_b_sel_i = 2'($urandom_range(0, 3));
      cu_f_i     = 3'($urandom_range(0, 7));
      {cu_write_a_i, cu_write_b_i, cu_write_o_i, cu_write_cz_i, cu_write_pc_i, cu_pc_sel_i} = 6'($urandom);
      in_valid_i = ($urandom_range(0, 2) != 0);
      jmp_tgt    = 8'($urandom_range(0, 7));
   endtask

   task automatic quiet_inputs();
      run_i = 0; step_i = 0; halt_i = 0; bp_en_i = 0; bp_addr_i = 8'h00;
      cu_b_sel_i = 2'd0; cu_f_i = 3'd5; jmp_tgt = 8'd0; in_valid_i = 0;
      {cu_write_a_i, cu_write_b_i, cu_write_o_i, cu_write_cz_i, cu_write_pc_i, cu_pc_sel_i} = 6'b100100;
      for (int i = 0; i < 8; i++) rom[i] = 8'h01;
   endtask

   initial begin
      int base;
      rstn = 1'b0;
      pc_i = 8'd0;
      quiet_inputs();
      fork
         run_model();
      join_none

      // Run a 3-instruction program ending in HALT_OPC
      rom[3] = 8'hFF;
      do_reset();
      run_i = 1;
      base = n_wa_tot;
      tick(20);
      sample();
      chk("t1_cnt", instr_cnt_o, 16'd3);
      chk("t1_halted", {halted_o, state_o}, {1'b1, 3'd4});
      chk("t1_wa_pulses", n_wa_tot - base, 3);

      // Single-step three instructions
      quiet_inputs();
      do_reset();
      base = n_wa_tot;
      for (int s = 0; s < 3; s++) begin
         tick(1); step_i = 1; tick(1); step_i = 0; tick(4);
         sample();
         chk("t2_idle", state_o, 3'd0);
      end
      chk("t2_cnt", instr_cnt_o, 16'd3);
      chk("t2_wa_pulses", n_wa_tot - base, 3);

      // Breakpoint at 04: trap, step through, trap again on next lap
      quiet_inputs();
      bp_en_i = 1; bp_addr_i = 8'h04;
      do_reset();
      run_i = 1;
      wait_state(3'd1, 1'b1, 8'h04, 40, "t3_reach1");
      run_i = 0;
      sample();
      chk("t3_trap", {state_o, bp_hit_o, pc_i}, {3'd0, 1'b1, 8'h04});
      chk("t3_cnt1", instr_cnt_o, 16'd4);
      tick(1); step_i = 1; tick(1); step_i = 0; tick(2);
      sample();
      chk("t3_step", {state_o, bp_hit_o, pc_i}, {3'd0, 1'b0, 8'h05});
      chk("t3_cnt2", instr_cnt_o, 16'd5);
      run_i = 1;
      wait_state(3'd1, 1'b1, 8'h04, 40, "t3_reach2");
      run_i = 0;
      sample();
      chk("t3_trap2", {state_o, bp_hit_o}, {3'd0, 1'b1});
      chk("t3_cnt3", instr_cnt_o, 16'd12);

      // Switch input handshake, then halt while waiting
      quiet_inputs();
      cu_b_sel_i = 2'd2;
      do_reset();
      run_i = 1;
      base = n_wa_tot;
      tick(8);
      sample();
      chk("t4_wait", {state_o, instr_cnt_o}, {3'd3, 16'd0});
      chk("t4_no_strobe", n_wa_tot - base, 0);
      in_valid_i = 1; run_i = 0;
      sample();
      chk("t4_ack", {state_o, in_ack_o, write_a_o}, {3'd2, 1'b1, 1'b1});
      tick(1);
      in_valid_i = 0;
      sample();
      chk("t4_done", {state_o, in_ack_o, instr_cnt_o}, {3'd0, 1'b0, 16'd1});
      run_i = 1;
      wait_state(3'd3, 1'b0, 8'h00, 10, "t5_wait");
      halt_i = 1;
      sample();
      chk("t5_abort", {state_o, instr_cnt_o, pc_i}, {3'd0, 16'd1, 8'h01});
      halt_i = 0; run_i = 0;

      // Reset in the middle of a committing EXEC
      quiet_inputs();
      do_reset();
      run_i = 1;
      tick(4);
      sample();
      chk("t6_exec", {state_o, write_a_o, instr_cnt_o}, {3'd2, 1'b1, 16'd1});
      #1 rstn = 1'b0;
      #1;
      chk("t6_async", {write_a_o, pc_inc_o, state_o, instr_cnt_o}, {1'b0, 1'b0, 3'd0, 16'd0});
      tick(2);
      rstn = 1'b1;

      // Long run: 16-bit counter tracks, 4-bit twin saturates
      tick(60);
      sample();
      chk("t6_cnt16", instr_cnt_o, 16'd29);
      chk("t6_cnt4_sat", s_cnt, 4'hF);

      // Randomized traffic with periodic reset and fresh program
      for (int seg = 0; seg < 12; seg++) begin
         for (int i = 0; i < 8; i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
         bp_en_i   = ($urandom_range(0, 2) == 0);
         bp_addr_i = 8'($urandom_range(0, 7));
         rand_inputs();
         do_reset();
         for (int c = 0; c < 250; c++) begin
            tick(1);
            rand_inputs();
         end
      end

      tick(2);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/execute sequencer for the 8-bit CPU datapath. It sits between the combinational ControlUnit and the state elements: PC/MUX, A/B/Y registers and the ALU flag register. It gates the raw ControlUnit strobes so each instruction commits in exactly one EXEC cycle. It adds run/step/halt control, a PC breakpoint, a switch-input handshake and a retired-instruction counter.

Parameters:
HALT_OPC, 8'hFF, opcode that parks the CPU in HALTED
SW_SEL, 2'd2, B_sel encoding selecting the input switches
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
run_i  in  1  level; continuous execution while high
step_i  in  1  single-cycle pulse; execute one instruction
halt_i  in  1  level; stop after current instruction
bp_en_i  in  1  breakpoint enable
bp_addr_i  in  8  breakpoint PC value
pc_i  in  8  current PC (addr_PC)
opcode_i  in  8  ROM output (registered ROM, valid 1 cycle after FETCH)
cu_b_sel_i  in  2  ControlUnit B-mux select
cu_f_i  in  3  ControlUnit ALU function
cu_write_a_i, cu_write_b_i, cu_write_o_i, cu_write_cz_i, cu_write_pc_i, cu_pc_sel_i  in  1 each  raw ControlUnit strobes
in_valid_i  in  1  switch value valid
in_ack_o  out  1  switch value consumed
write_a_o, write_b_o, write_o_o, write_cz_o, write_pc_o  out  1 each  gated strobes
pc_sel_o  out  1  gated PC mux select
pc_inc_o  out  1  sequential PC advance
f_o  out  3  ALU function, passed through
b_sel_o  out  2  B select, passed through
state_o  out  3  current state encoding
bp_hit_o  out  1  sticky; breakpoint stopped execution
halted_o  out  1  HALTED state reached
instr_cnt_o  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset is asynchronous, active-low:
  - state=IDLE; instr_cnt_o=0; bp_hit_o=0; bp_skip=0; step_mode=0.
  - All strobes, in_ack_o and pc_inc_o are 0.
- States: IDLE=0, FETCH=1, EXEC=2, WAIT_IN=3, HALTED=4.
- IDLE:
  - step_i → FETCH with step_mode=1. step_i wins over run_i when both are high.
  - Else run_i && !halt_i → FETCH with step_mode=0.
  - Any exit from IDLE clears bp_hit_o.
- FETCH (1 cycle; ROM addressed by pc_i, no strobes):
  - If bp_en_i && pc_i==bp_addr_i && !bp_skip → IDLE, set bp_hit_o=1 and bp_skip=1.
  - Else → EXEC.
- EXEC, evaluated in priority order:
  - opcode_i==HALT_OPC → HALTED. No strobes, counter unchanged.
  - cu_b_sel_i==SW_SEL && !in_valid_i → WAIT_IN. No strobes.
  - Otherwise commit for exactly this one cycle:
    - Each write_*_o equals its cu_*_i.
    - pc_sel_o equals cu_pc_sel_i.
    - pc_inc_o = !cu_write_pc_i.
    - in_ack_o = (cu_b_sel_i==SW_SEL).
    - instr_cnt_o increments, holding at all-ones.
    - bp_skip clears.
  - After commit: next state is IDLE if step_mode || halt_i || !run_i, else FETCH.
- WAIT_IN (no strobes):
  - halt_i → IDLE. Instruction is not retired; PC is unchanged, so the instruction re-fetches on resume.
  - Else in_valid_i → EXEC. The commit happens in EXEC with in_ack_o=1.
- HALTED: absorbing; only rstn exits. halted_o=1.
- Outside a committing EXEC cycle, every write_*_o, pc_sel_o, pc_inc_o and in_ack_o is 0.
- f_o and b_sel_o pass through combinationally at all times.
- Strobe and handshake outputs are combinational from state and inputs. state_o, bp_hit_o, instr_cnt_o and halted_o are registered.
- Instruction latency is 2 cycles (FETCH+EXEC), plus any WAIT_IN cycles.
- halt_i asserted mid-instruction never aborts a committing EXEC.

Decomposition:
- Shared package cpu_seq_pkg holds:
  - state enum seq_state_t.
  - HALT_OPC and SW_SEL defaults.
  - state encodings used by the display/debug logic.
- One sub-module, sat_counter: a CNT_W-wide saturating increment-enable counter with async active-low reset.

Test Plan:
1. Reset, run_i=1, program of 3 ALU ops then HALT_OPC → strobes each exactly 1 cycle at cycles 2, 4, 6; HALTED at cycle 8; instr_cnt_o=3; halted_o=1.
2. run_i=0, three step_i pulses → three instructions retire, IDLE after each; instr_cnt_o=3; no strobe while idle.
3. bp_en_i=1, bp_addr_i=8'h04, run → stop in IDLE with pc_i=04 and bp_hit_o=1. step_i → the instruction at 04 executes and bp_hit_o clears. Next pass through 04 traps again.
4. Switch instruction (cu_b_sel_i=2) with in_valid_i=0 for 5 cycles → WAIT_IN; no strobes. Raise in_valid_i → next cycle commits with in_ack_o=1 for 1 cycle.
5. halt_i rises during WAIT_IN → IDLE; counter unchanged; PC unchanged.
6. rstn low mid-EXEC → strobes drop immediately; state=IDLE; counter=0. Preload counter to FFFF, retire one more instruction → stays FFFF.
